// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
// Holds FSM state codes, owner codes and a counter width helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  function automatic int cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_ready,
    output dm_rdata, dm_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall, busy
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_ready,
    input  dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall, busy
  );
endinterface

// File: rtl/mem_port_arbiter_latency_counter.sv
// Access latency counter: loads LATENCY-1, counts down, flags zero.
// Module name arb_latency_counter.
module arb_latency_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);
  localparam int W = cnt_w(LATENCY);
  localparam logic [W-1:0] LOAD = W'(LATENCY - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD;
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and MEM, freezing the pipeline.
// ARB_ROUND_ROBIN_EN: alternate contended grants instead of data-first.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_e r_state;
  arb_state_e w_next;
  arb_owner_e r_owner;
  arb_owner_e w_sel;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic r_we;
  logic r_if_done;
  logic r_dm_done;
  logic w_pend_i;
  logic w_pend_d;
  logic w_grant;
  logic w_fin;
  logic w_zero;
  logic w_stall;
  logic w_acc;

  assign w_pend_i = bus.if_req & ~r_if_done;
  assign w_pend_d = bus.dm_req & ~r_dm_done;
  assign w_stall  = w_pend_i | w_pend_d;
  assign w_acc    = (r_state == ARB_ACCESS);

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= OWN_IF;
    end else if (w_grant) begin
      r_last <= w_sel;
    end
  end

  always_comb begin
    w_sel = w_pend_d ? OWN_DM : OWN_IF;
    if (w_pend_d && w_pend_i) begin
      w_sel = (r_last == OWN_DM) ? OWN_IF : OWN_DM;
    end
  end
`else
  assign w_sel = w_pend_d ? OWN_DM : OWN_IF;
`endif

  arb_latency_counter #(
    .LATENCY (LATENCY)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_grant),
    .i_dec  (w_acc),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_fin   = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_stall) begin
          w_grant = 1'b1;
          w_next  = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (w_zero) begin
          w_fin  = 1'b1;
          w_next = ARB_RESP;
        end
      end
      ARB_RESP: w_next = ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= OWN_IF;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_owner <= w_sel;
      r_addr  <= (w_sel == OWN_DM) ? bus.dm_addr : bus.if_addr;
      r_we    <= (w_sel == OWN_DM) & bus.dm_we;
      r_wdata <= bus.dm_wdata;
    end
  end

  // Done is raised on the last access edge so ready shows in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_done  <= 1'b0;
      r_dm_done  <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_fin && r_owner == OWN_IF && bus.if_req) begin
        r_if_done <= 1'b1;
      end else if (!w_stall || !bus.if_req) begin
        r_if_done <= 1'b0;
      end
      if (w_fin && r_owner == OWN_DM && bus.dm_req) begin
        r_dm_done <= 1'b1;
      end else if (!w_stall || !bus.dm_req) begin
        r_dm_done <= 1'b0;
      end
      if (w_fin && r_owner == OWN_IF) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (w_fin && r_owner == OWN_DM && !r_we) begin
        r_dm_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = w_acc;
  assign bus.mem_we    = w_acc & r_we & (r_owner == OWN_DM);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_ready  = r_if_done;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.dm_ready  = r_dm_done;
  assign bus.stall     = w_stall;
  assign bus.busy      = (r_state != ARB_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random pipeline traffic against a timeline model of the arbiter.
// Define ARB_ROUND_ROBIN_EN to check the alternating grant variant.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: a transaction granted at cycle g owns the memory for
  // cycles g+1..g+LAT, ready shows from g+LAT+1, port free at g+LAT+2.
  int   t;
  int   g_t;
  bit   m_own_d;
  bit   m_we;
  bit   m_last_d;
  bit   m_ifd;
  bit   m_dmd;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_ifr;
  logic [31:0] m_dmr;
  bit   adv;

  task automatic model_reset();
    g_t = -1;
    m_own_d = 0;
    m_we = 0;
    m_last_d = 0;
    m_ifd = 0;
    m_dmd = 0;
    m_addr = '0;
    m_wdata = '0;
    m_ifr = '0;
    m_dmr = '0;
    adv = 1;
  endtask

  task automatic check_outputs();
    int d;
    bit acc;
    bit resp;
    bit st;
    d = (g_t >= 0) ? t - g_t : -1;
    acc = (d >= 1) && (d <= LAT);
    resp = (d == LAT + 1);
    st = (bus.if_req & ~m_ifd) | (bus.dm_req & ~m_dmd);
    chk("mem_en", 32'(bus.mem_en), 32'(acc));
    chk("mem_we", 32'(bus.mem_we), 32'(acc & m_we & m_own_d));
    chk("busy", 32'(bus.busy), 32'(acc | resp));
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("if_ready", 32'(bus.if_ready), 32'(m_ifd));
    chk("dm_ready", 32'(bus.dm_ready), 32'(m_dmd));
    chk("if_rdata", bus.if_rdata, m_ifr);
    chk("dm_rdata", bus.dm_rdata, m_dmr);
    chk("stall", 32'(bus.stall), 32'(st));
  endtask

  task automatic model_step();
    int d;
    bit st;
    bit n_ifd;
    bit n_dmd;
    bit pi;
    bit pd;
    d = (g_t >= 0) ? t - g_t : -1;
    pi = bus.if_req & ~m_ifd;
    pd = bus.dm_req & ~m_dmd;
    st = pi | pd;
    n_ifd = (!st || !bus.if_req) ? 1'b0 : m_ifd;
    n_dmd = (!st || !bus.dm_req) ? 1'b0 : m_dmd;
    if (d == LAT) begin
      if (m_own_d) begin
        if (!m_we) m_dmr = bus.mem_rdata;
        if (bus.dm_req) n_dmd = 1;
      end else begin
        m_ifr = bus.mem_rdata;
        if (bus.if_req) n_ifd = 1;
      end
    end
    if (d == LAT + 1) g_t = -1;
    else if (g_t < 0 && st) begin
`ifdef ARB_ROUND_ROBIN_EN
      m_own_d = (pi && pd) ? !m_last_d : pd;
      m_last_d = m_own_d;
`else
      m_own_d = pd;
`endif
      g_t = t;
      m_we = m_own_d & bus.dm_we;
      m_addr = m_own_d ? bus.dm_addr : bus.if_addr;
      m_wdata = bus.dm_wdata;
    end
    m_ifd = n_ifd;
    m_dmd = n_dmd;
    adv = !st;
    t++;
  endtask

  // Pipeline-like driver: requests hold until the pipeline advances,
  // with occasional flushes.
  task automatic drive_inputs();
    if (!bus.if_req || adv) begin
      bus.if_req = ($urandom_range(0, 9) < 7);
      bus.if_addr = $urandom & 32'hFFFC;
    end else if ($urandom_range(0, 19) == 0) begin
      bus.if_req = 1'b0;
    end
    if (!bus.dm_req || adv) begin
      bus.dm_req = ($urandom_range(0, 9) < 5);
      bus.dm_we = $urandom_range(0, 1) == 1;
      bus.dm_addr = $urandom & 32'hFFFC;
      bus.dm_wdata = $urandom;
    end else if ($urandom_range(0, 39) == 0) begin
      bus.dm_req = 1'b0;
    end
    bus.mem_rdata = $urandom;
  endtask

  initial begin
    bit in_rst;
    bus.if_req = 0;
    bus.if_addr = '0;
    bus.dm_req = 0;
    bus.dm_we = 0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    bus.mem_rdata = '0;
    t = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    in_rst = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (in_rst) begin
        rst = 1'b1;
        in_rst = 0;
      end
      drive_inputs();
      #1;
      check_outputs();
      if (c > 20 && $urandom_range(0, 149) == 0) begin
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        in_rst = 1;
      end else begin
        model_step();
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
